fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
- Fetch-stage PC generator and instruction-memory requester; it is the consumer of the Decode-stage `branch` redirect.
- Holds the architectural fetch PC and issues word fetches to instruction memory.
- Presents fetched instructions to the IF/ID register with a valid/ready handshake.
- On a redirect it restarts fetch at the branch target, flushes wrong-path instructions and discards any in-flight wrong-path response.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0013, value driven on if_instr when no valid instruction is held.

Ports:
- clk  in  1  core clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- branch  in  1  redirect request from the Decode-stage branch resolver, already qualified.
- branch_target  in  32  redirect target address.
- id_ready  in  1  Decode accepts if_instr this cycle.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch word address, bits[1:0] always 0.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response valid; at most one outstanding, in order, at least 1 cycle after grant.
- imem_rdata  in  32  response instruction word.
- if_valid  out  1  if_instr/if_pc hold a valid instruction.
- if_pc  out  32  PC of if_instr.
- if_instr  out  32  instruction to IF/ID.
- fetch_pc  out  32  next address to request (pc_q).

Behaviour:
- Reset (async, rst_n=0):
  - pc_q=RESET_PC, state=BOOT, imem_req=0.
  - if_valid=0, if_pc=0, if_instr=NOP_INSTR.
  - Skid buffer empty.
- Storage: output register (OUT) plus a 1-entry skid register (SKID), each holding {pc, instr}. A response goes to OUT if OUT is empty or consumed this cycle (if_valid & id_ready); otherwise it goes to SKID. When OUT is consumed and SKID is full, SKID moves to OUT.
- States:
  - BOOT: one idle cycle after reset release, then go to ISSUE.
  - ISSUE: imem_req=1 when SKID is empty; imem_addr=pc_q. On imem_gnt: pc_q+=4, record the request PC, go to WAIT.
  - WAIT: imem_req=0 unless imem_rvalid=1 this cycle and SKID will be empty next cycle. In that case a back-to-back request is issued for pc_q the same cycle. On rvalid the response is delivered tagged with the recorded PC. Then: stay in WAIT if the new request was granted; otherwise go to ISSUE.
  - KILL: wait for the wrong-path response. On imem_rvalid, discard it and go to ISSUE. No request is issued in KILL.
- Redirect (branch=1) has priority over every other event in the same cycle:
  - Next cycle: pc_q=branch_target & ~32'h3. OUT and SKID are cleared; any consume this cycle is still honoured by Decode.
  - A response arriving this cycle is discarded.
  - Next state:
    - KILL if a request is outstanding after this cycle. This covers WAIT with no rvalid this cycle, and a request granted this cycle.
    - ISSUE otherwise.
  - branch while in KILL: pc_q is updated and the state stays KILL.
- Latency:
  - Redirect to first target request: 1 cycle, or after the kill drains.
  - Grant to if_valid: 1 cycle after rvalid.
  - Sustained throughput: 1 instruction per cycle when the memory grants immediately and responds 1 cycle later.
- Stall: with id_ready=0, OUT holds and SKID fills. No new request is issued while SKID is full, so no response is ever lost.
- Wrap-around: pc_q increments modulo 2^32; 32'hFFFF_FFFC+4 = 32'h0.
- imem_addr and request PC tags always have bits[1:0]=0.
- If if_valid=0, if_instr=NOP_INSTR and if_pc holds its last value.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds outputs redirect_cnt[31:0] and stall_cnt[31:0], both reset to 0 and wrapping.
  - redirect_cnt increments on each cycle with branch=1.
  - stall_cnt increments on each cycle with if_valid=1 & id_ready=0.
- Undefined: the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset then free-run; memory gnt=1, rvalid 1 cycle after grant, id_ready=1 → requests 0x0,0x4,0x8… on consecutive cycles; if_pc follows 0x0,0x4,0x8 with the matching rdata.
- Stall: hold id_ready=0 for 4 cycles mid-stream → OUT holds PC 0x8, SKID holds 0xC, no request while SKID is full. On release: 0x8 then 0xC, no loss or duplication.
- Redirect in WAIT: request 0x10 granted, branch=1 target 0x200 before rvalid → state KILL; the 0x10 response is dropped; next imem_addr=0x200; if_valid=0 until the 0x200 response.
- Redirect coincident with rvalid and a fresh grant → response dropped, granted wrong-path request killed, next request 0x200.
- branch_target=0x203 → imem_addr=0x200.
- Start at pc 0xFFFF_FFFC → next request 0x0000_0000.
- FETCH_PERF_CNT_EN: 3 redirects and 5 stall cycles → redirect_cnt=3, stall_cnt=5.

Source files
------------

// File: rtl/fetch_pc_if.sv
// Fetch unit bus: Decode redirect/handshake, instruction-memory request/response,
// and the IF/ID output. master = fetch_pc_unit side, slave = surrounding pipeline.
interface fetch_pc_if;
  logic        branch;
  logic [31:0] branch_target;
  logic        id_ready;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [31:0] fetch_pc;

  modport master (
    input  branch, branch_target, id_ready, imem_gnt, imem_rvalid, imem_rdata,
    output imem_req, imem_addr, if_valid, if_pc, if_instr, fetch_pc
  );

  modport slave (
    output branch, branch_target, id_ready, imem_gnt, imem_rvalid, imem_rdata,
    input  imem_req, imem_addr, if_valid, if_pc, if_instr, fetch_pc
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC generator: issues word fetches, buffers responses in an output
// register plus a one-entry skid, and squashes wrong-path work on a redirect.
// Optional macro FETCH_PERF_CNT_EN adds redirect_cnt / stall_cnt outputs.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic       clk,
  input  logic       rst_n,
  fetch_pc_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] redirect_cnt,
  output logic [31:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {BOOT, ISSUE, WAIT, KILL} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, req_pc_q;
  logic        out_vld_q, skid_vld_q;
  logic [31:0] out_pc_q, out_instr_q, skid_pc_q, skid_instr_q;
  logic        consume, rsp_in, skid_busy_nxt, req, fire;

  // A response is only accepted in WAIT; KILL responses are wrong-path.
  assign consume = out_vld_q & bus.id_ready;
  assign rsp_in  = (state_q == WAIT) & bus.imem_rvalid;

  // Skid occupancy after this cycle, ignoring a redirect (which only empties it).
  always_comb begin
    skid_busy_nxt = consume ? (skid_vld_q & rsp_in) : (skid_vld_q | (out_vld_q & rsp_in));
  end

  // Request generation and next state; a redirect overrides the normal transition.
  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    case (state_q)
      BOOT:  state_d = ISSUE;
      ISSUE: begin
        req = ~skid_vld_q;
        if (req & bus.imem_gnt) state_d = WAIT;
      end
      WAIT: begin
        req = bus.imem_rvalid & ~skid_busy_nxt;
        if (bus.imem_rvalid) state_d = (req & bus.imem_gnt) ? WAIT : ISSUE;
      end
      KILL:  if (bus.imem_rvalid) state_d = ISSUE;
      default: state_d = BOOT;
    endcase
    fire = req & bus.imem_gnt;
    // Anything still owed by memory after this cycle must be drained in KILL.
    if (bus.branch)
      state_d = (fire | (((state_q == WAIT) | (state_q == KILL)) & ~bus.imem_rvalid)) ? KILL : ISSUE;
  end

  // State, fetch PC and the PC tag of the outstanding request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= BOOT;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
    end else begin
      state_q <= state_d;
      if (fire) req_pc_q <= pc_q;
      if (bus.branch)  pc_q <= bus.branch_target & ~32'h3;
      else if (fire)   pc_q <= pc_q + 32'd4;
    end
  end

  // OUT/SKID buffering: responses fill OUT first, SKID only while OUT is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q    <= 1'b0;
      out_pc_q     <= 32'h0;
      out_instr_q  <= NOP_INSTR;
      skid_vld_q   <= 1'b0;
      skid_pc_q    <= 32'h0;
      skid_instr_q <= NOP_INSTR;
    end else if (bus.branch) begin
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
    end else if (consume) begin
      if (skid_vld_q) begin
        out_vld_q   <= 1'b1;
        out_pc_q    <= skid_pc_q;
        out_instr_q <= skid_instr_q;
        skid_vld_q  <= rsp_in;
        if (rsp_in) begin
          skid_pc_q    <= req_pc_q;
          skid_instr_q <= bus.imem_rdata;
        end
      end else begin
        out_vld_q <= rsp_in;
        if (rsp_in) begin
          out_pc_q    <= req_pc_q;
          out_instr_q <= bus.imem_rdata;
        end
      end
    end else if (rsp_in) begin
      if (out_vld_q) begin
        skid_vld_q   <= 1'b1;
        skid_pc_q    <= req_pc_q;
        skid_instr_q <= bus.imem_rdata;
      end else begin
        out_vld_q   <= 1'b1;
        out_pc_q    <= req_pc_q;
        out_instr_q <= bus.imem_rdata;
      end
    end
  end

  assign bus.imem_req  = req;
  assign bus.imem_addr = pc_q;
  assign bus.fetch_pc  = pc_q;
  assign bus.if_valid  = out_vld_q;
  assign bus.if_pc     = out_pc_q;
  assign bus.if_instr  = out_vld_q ? out_instr_q : NOP_INSTR;

`ifdef FETCH_PERF_CNT_EN
  // Wrapping event counters: redirects and cycles Decode back-pressures a valid instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_cnt <= 32'h0;
      stall_cnt    <= 32'h0;
    end else begin
      if (bus.branch)                redirect_cnt <= redirect_cnt + 32'd1;
      if (out_vld_q & ~bus.id_ready) stall_cnt    <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed vector table, redirect/wrap sequences and a
// randomized run checked by an instruction-stream scoreboard and memory model.
module tb_fetch_pc_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_pc_if f();
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] redirect_cnt, stall_cnt;
`endif

  fetch_pc_unit #(.RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .bus(f)
`ifdef FETCH_PERF_CNT_EN
    , .redirect_cnt(redirect_cnt), .stall_cnt(stall_cnt)
`endif
  );

  int tests = 0, fails = 0;
  int gnt_pct = 100, lat = 0;
  bit pend;
  int cnt;
  logic [31:0] paddr, exp_pc, exp_req;
  int consumed, m_redir, m_stall;
  logic s_req, s_valid;
  logic [31:0] s_addr, s_pc, s_instr, s_fpc;

  typedef struct {
    logic rdy; logic req; logic [31:0] addr; logic vld; logic [31:0] pc; logic [31:0] fpc;
  } vec_t;
  vec_t tbl[13];

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0001;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: sample outputs at negedge, score them, then advance the memory model.
  task automatic cycle();
    logic fire, rsp, br, rdy;
    logic [31:0] tgt;
    @(negedge clk);
    s_req = f.imem_req; s_addr = f.imem_addr; s_valid = f.if_valid;
    s_pc = f.if_pc; s_instr = f.if_instr; s_fpc = f.fetch_pc;
    rsp = f.imem_rvalid; fire = s_req & f.imem_gnt;
    br = f.branch; rdy = f.id_ready; tgt = f.branch_target;
    if (!s_valid) chk("idle_nop", s_instr, NOP);
    if (s_req) chk("addr_align", {30'd0, s_addr[1:0]}, 32'd0);
    if (fire) chk("one_outstanding", {31'd0, pend & ~rsp}, 32'd0);
    if (fire && !br) begin chk("req_addr", s_addr, exp_req); exp_req = exp_req + 32'd4; end
    if (s_valid && rdy) begin
      chk("deliver_pc", s_pc, exp_pc);
      chk("deliver_instr", s_instr, mem(exp_pc));
      exp_pc = exp_pc + 32'd4;
      consumed++;
    end
    if (s_valid && !rdy) m_stall++;
    if (br) begin m_redir++; exp_pc = tgt & ~32'h3; exp_req = tgt & ~32'h3; end
    @(posedge clk); #1;
    if (rsp) pend = 1'b0;
    if (fire) begin pend = 1'b1; paddr = s_addr; cnt = lat; end
    else if (pend && cnt > 0) cnt--;
    f.imem_rvalid = pend && (cnt == 0);
    f.imem_rdata  = (pend && cnt == 0) ? mem(paddr) : 32'hDEAD_BEEF;
    f.imem_gnt    = ($urandom_range(99) < gnt_pct);
    f.branch      = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    f.branch = 1'b0; f.branch_target = 32'h0; f.id_ready = 1'b1;
    f.imem_rvalid = 1'b0; f.imem_rdata = 32'h0; f.imem_gnt = 1'b0;
    pend = 1'b0; cnt = 0; exp_pc = 32'h0; exp_req = 32'h0;
    consumed = 0; m_redir = 0; m_stall = 0;
    @(posedge clk); @(negedge clk);
    chk("rst_req", {31'd0, f.imem_req}, 32'd0);
    chk("rst_valid", {31'd0, f.if_valid}, 32'd0);
    chk("rst_if_pc", f.if_pc, 32'h0);
    chk("rst_if_instr", f.if_instr, NOP);
    chk("rst_fetch_pc", f.fetch_pc, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    f.imem_gnt = ($urandom_range(99) < gnt_pct);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int n, found;
    // Free-run from reset, 4-cycle Decode stall in the middle (cycles 5..8).
    //            rdy   req   addr        vld   if_pc       fetch_pc
    tbl[0]  = '{1'b1, 1'b0, 32'h00, 1'b0, 32'h00, 32'h00};
    tbl[1]  = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00, 32'h00};
    tbl[2]  = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00, 32'h04};
    tbl[3]  = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h00, 32'h08};
    tbl[4]  = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h04, 32'h0C};
    tbl[5]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h08, 32'h10};
    tbl[6]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h08, 32'h10};
    tbl[7]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h08, 32'h10};
    tbl[8]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h08, 32'h10};
    tbl[9]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h08, 32'h10};
    tbl[10] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h0C, 32'h10};
    tbl[11] = '{1'b1, 1'b1, 32'h14, 1'b0, 32'h0C, 32'h14};
    tbl[12] = '{1'b1, 1'b1, 32'h18, 1'b1, 32'h10, 32'h18};

    gnt_pct = 100; lat = 0;
    do_reset();
    for (int i = 0; i < 13; i++) begin
      f.id_ready = tbl[i].rdy;
      cycle();
      chk($sformatf("vec%0d_req", i), {31'd0, s_req}, {31'd0, tbl[i].req});
      if (tbl[i].req) chk($sformatf("vec%0d_addr", i), s_addr, tbl[i].addr);
      chk($sformatf("vec%0d_valid", i), {31'd0, s_valid}, {31'd0, tbl[i].vld});
      chk($sformatf("vec%0d_if_pc", i), s_pc, tbl[i].pc);
      chk($sformatf("vec%0d_if_instr", i), s_instr, tbl[i].vld ? mem(tbl[i].pc) : NOP);
      chk($sformatf("vec%0d_fetch_pc", i), s_fpc, tbl[i].fpc);
    end

    // Redirect while waiting for the 0x10 response (memory latency 3 cycles).
    gnt_pct = 100; lat = 2;
    do_reset();
    found = 0;
    for (int i = 0; i < 60 && found == 0; i++) begin
      cycle();
      if (s_req && s_addr == 32'h10) found = 1;
    end
    chk("A_saw_req_0x10", found, 1);
    f.branch = 1'b1; f.branch_target = 32'h200;
    cycle();
    n = 0;
    do begin
      cycle(); n++;
      chk("A_valid_in_kill", {31'd0, s_valid}, 32'd0);
    end while (!s_req && n < 10);
    chk("A_kill_cycles", n, 3);
    chk("A_first_target_addr", s_addr, 32'h200);
    n = 0;
    do begin cycle(); n++; end while (!s_valid && n < 10);
    chk("A_first_valid_pc", s_pc, 32'h200);

    // Redirect coincident with rvalid and a fresh grant; unaligned target.
    gnt_pct = 100; lat = 0;
    do_reset();
    for (int i = 0; i < 5; i++) cycle();
    f.branch = 1'b1; f.branch_target = 32'h203;
    cycle();
    chk("B_granted_0x10", {s_req, s_addr[30:0]}, {1'b1, 31'h10});
    cycle();
    chk("B_kill_req", {31'd0, s_req}, 32'd0);
    chk("B_kill_valid", {31'd0, s_valid}, 32'd0);
    cycle();
    chk("B_target_req", {31'd0, s_req}, 32'd1);
    chk("B_target_addr", s_addr, 32'h200);
    chk("B_fetch_pc", s_fpc, 32'h200);
    cycle();
    chk("B_not_yet_valid", {31'd0, s_valid}, 32'd0);
    cycle();
    chk("B_valid", {31'd0, s_valid}, 32'd1);
    chk("B_valid_pc", s_pc, 32'h200);

    // PC wrap-around from 0xFFFF_FFFC.
    do_reset();
    for (int i = 0; i < 3; i++) cycle();
    f.branch = 1'b1; f.branch_target = 32'hFFFF_FFFC;
    cycle();
    cycle();
    chk("W_kill_req", {31'd0, s_req}, 32'd0);
    cycle();
    chk("W_top_addr", s_addr, 32'hFFFF_FFFC);
    cycle();
    chk("W_wrap_addr", s_addr, 32'h0);
    for (int i = 0; i < 6; i++) cycle();

`ifdef FETCH_PERF_CNT_EN
    // 5 stall cycles then 3 redirects.
    do_reset();
    for (int i = 0; i < 4; i++) cycle();
    f.id_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin f.id_ready = 1'b0; cycle(); end
    f.id_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    for (int k = 0; k < 3; k++) begin
      f.branch = 1'b1; f.branch_target = 32'h400;
      cycle();
      for (int i = 0; i < 3; i++) cycle();
    end
    chk("P_redirect_cnt", redirect_cnt, 32'd3);
    chk("P_stall_cnt", stall_cnt, 32'd5);
`endif

    // Randomized traffic against the stream scoreboard.
    gnt_pct = 70;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      lat = $urandom_range(3);
      f.id_ready = ($urandom_range(99) < 75);
      if ($urandom_range(99) < 4) begin
        f.branch = 1'b1;
        case ($urandom_range(2))
          0: f.branch_target = $urandom;
          1: f.branch_target = 32'hFFFF_FFF0 | $urandom_range(15);
          default: f.branch_target = $urandom_range(255);
        endcase
      end
      cycle();
    end
    chk("R_progress", {31'd0, consumed > 100}, 32'd1);
`ifdef FETCH_PERF_CNT_EN
    chk("R_redirect_cnt", redirect_cnt, m_redir);
    chk("R_stall_cnt", stall_cnt, m_stall);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
